// File: rtl/rv32i_single_cycle_core.sv
// rv32i_single_cycle_core
//   Single-cycle RV32I integer core: one instruction fetched, decoded and
//   executed per clk. Register writes, PC update and memory stores all take
//   effect at the rising edge that ends the instruction's cycle.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   inst_addr_o  byte address of the current instruction (the PC)
//   inst_i       instruction word, combinational from inst_addr_o
//   inst_ce_o    fetch enable, registered, rises on the first edge after reset
//   data_ce_o    data access this cycle (LW or SW)
//   data_we_o    data write this cycle (SW)
//   data_addr_o  byte address rs1 + imm
//   data_i       load data, combinational from data_addr_o
//   data_o       store data (rs2)
module rv32i_single_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_i,
  output logic        inst_ce_o,
  output logic        data_ce_o,
  output logic        data_we_o,
  output logic [31:0] data_addr_o,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0] r_pc;
  logic        r_inst_ce;
  logic [31:0] r_regs [0:31];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_pc_plus4;
  logic        w_br_valid;
  logic        w_br_taken;
  logic        w_rd_we;
  logic [31:0] w_rd_wdata;
  logic [31:0] w_next_pc;
  logic        w_mem_re;
  logic        w_mem_we;
  logic [31:0] w_mem_addr;

  assign w_opcode = inst_i[6:0];
  assign w_rd     = inst_i[11:7];
  assign w_funct3 = inst_i[14:12];
  assign w_rs1    = inst_i[19:15];
  assign w_rs2    = inst_i[24:20];
  assign w_funct7 = inst_i[31:25];

  // Reads see the pre-edge contents, so a same-cycle write returns the old value.
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

  assign w_imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign w_imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign w_imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign w_imm_u = {inst_i[31:12], 12'b0};
  assign w_imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  assign w_pc_plus4 = r_pc + 32'd4;

  // Shared ALU for OP and OP-IMM; alt selects SUB / SRA.
  function automatic logic [31:0] alu(input logic [2:0]  f3,
                                      input logic        alt,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] res;
    case (f3)
      3'b000:  res = alt ? (a - b) : (a + b);
      3'b001:  res = a << b[4:0];
      3'b010:  res = {31'd0, ($signed(a) < $signed(b))};
      3'b011:  res = {31'd0, (a < b)};
      3'b100:  res = a ^ b;
      3'b101:  res = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  res = a | b;
      default: res = a & b;
    endcase
    return res;
  endfunction

  always_comb begin
    w_br_valid = 1'b1;
    w_br_taken = 1'b0;
    case (w_funct3)
      3'b000:  w_br_taken = (w_rs1_val == w_rs2_val);
      3'b001:  w_br_taken = (w_rs1_val != w_rs2_val);
      3'b100:  w_br_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
      3'b101:  w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      3'b110:  w_br_taken = (w_rs1_val <  w_rs2_val);
      3'b111:  w_br_taken = (w_rs1_val >= w_rs2_val);
      default: w_br_valid = 1'b0;
    endcase
  end

  // Anything not recognised below (including invalid funct3/funct7 encodings)
  // falls through with defaults: PC+4, no register or memory write.
  always_comb begin
    w_rd_we    = 1'b0;
    w_rd_wdata = 32'd0;
    w_next_pc  = w_pc_plus4;
    w_mem_re   = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_addr = w_rs1_val + w_imm_i;
    if (r_inst_ce) begin
      case (w_opcode)
        OPC_LUI: begin
          w_rd_we    = 1'b1;
          w_rd_wdata = w_imm_u;
        end
        OPC_AUIPC: begin
          w_rd_we    = 1'b1;
          w_rd_wdata = r_pc + w_imm_u;
        end
        OPC_JAL: begin
          w_rd_we    = 1'b1;
          w_rd_wdata = w_pc_plus4;
          w_next_pc  = r_pc + w_imm_j;
        end
        OPC_JALR: begin
          if (w_funct3 == 3'b000) begin
            w_rd_we    = 1'b1;
            w_rd_wdata = w_pc_plus4;
            w_next_pc  = (w_rs1_val + w_imm_i) & ~32'd1;
          end
        end
        OPC_BRANCH: begin
          if (w_br_valid && w_br_taken) w_next_pc = r_pc + w_imm_b;
        end
        OPC_LOAD: begin
          if (w_funct3 == 3'b010) begin
            w_mem_re   = 1'b1;
            w_rd_we    = 1'b1;
            w_rd_wdata = data_i;
          end
        end
        OPC_STORE: begin
          w_mem_addr = w_rs1_val + w_imm_s;
          if (w_funct3 == 3'b010) w_mem_we = 1'b1;
        end
        OPC_OPIMM: begin
          // SLLI needs funct7 = 0; SRLI/SRAI allow 0 or 0100000.
          if ((w_funct3 == 3'b001 && w_funct7 == 7'h00) ||
              (w_funct3 == 3'b101 && (w_funct7 == 7'h00 || w_funct7 == 7'h20)) ||
              (w_funct3 != 3'b001 && w_funct3 != 3'b101)) begin
            w_rd_we    = 1'b1;
            w_rd_wdata = alu(w_funct3, (w_funct3 == 3'b101) && inst_i[30], w_rs1_val, w_imm_i);
          end
        end
        OPC_OP: begin
          if (w_funct7 == 7'h00 ||
              (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
            w_rd_we    = 1'b1;
            w_rd_wdata = alu(w_funct3, inst_i[30], w_rs1_val, w_rs2_val);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_inst_ce <= 1'b0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else begin
      r_inst_ce <= 1'b1;
      if (r_inst_ce) r_pc <= w_next_pc;
      if (w_rd_we && (w_rd != 5'd0)) r_regs[w_rd] <= w_rd_wdata;
    end
  end

  assign inst_addr_o = r_pc;
  assign inst_ce_o   = r_inst_ce;
  assign data_ce_o   = w_mem_re | w_mem_we;
  assign data_we_o   = w_mem_we;
  assign data_addr_o = w_mem_addr;
  assign data_o      = w_rs2_val;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Bench for rv32i_single_cycle_core: a directed program with known results,
// then random straight-line/forward-branch programs run in lockstep against
// an instruction-level reference model.
module tb_rv32i_single_cycle_core;

  logic        clk;
  logic        rst;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_i;
  logic        inst_ce_o;
  logic        data_ce_o;
  logic        data_we_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_i;
  logic [31:0] data_o;

  rv32i_single_cycle_core #(.RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_addr_o (inst_addr_o),
    .inst_i      (inst_i),
    .inst_ce_o   (inst_ce_o),
    .data_ce_o   (data_ce_o),
    .data_we_o   (data_we_o),
    .data_addr_o (data_addr_o),
    .data_i      (data_i),
    .data_o      (data_o)
  );

  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  logic [31:0] imem      [0:255];
  logic [31:0] dmem      [0:63];
  logic [31:0] dmem_init [0:63];

  assign inst_i = imem[inst_addr_o[9:2]];
  assign data_i = dmem[data_addr_o[7:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) dmem[i] <= dmem_init[i];
    end else if (data_ce_o && data_we_o) begin
      dmem[data_addr_o[7:2]] <= data_o;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int we_count;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    return {imm[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input int rd, input logic [6:0] op);
    return {imm, 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'h6F};
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_regs [0:31];
  logic [31:0] m_dmem [0:63];

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < 64; i++) m_dmem[i] = dmem_init[i];
  endtask

  // Executes one instruction on the model; reports the memory access it implies.
  task automatic model_step(input logic [31:0] ins, output logic e_ce, output logic e_we,
                            output logic [31:0] e_addr, output logic [31:0] e_wd);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, o, res, nxt, ii, is, ib, ij;
    logic        wr, tk, ok;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    a  = m_regs[ins[19:15]];
    b  = m_regs[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = m_pc + 32'd4;
    wr = 1'b0; res = 32'd0; tk = 1'b0;
    e_ce = 1'b0; e_we = 1'b0; e_addr = 32'd0; e_wd = 32'd0;
    case (op)
      7'h37: begin wr = 1'b1; res = {ins[31:12], 12'h000}; end
      7'h17: begin wr = 1'b1; res = m_pc + {ins[31:12], 12'h000}; end
      7'h6F: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + ij; end
      7'h67: if (f3 == 3'd0) begin wr = 1'b1; res = m_pc + 32'd4; nxt = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = (int'(a) <  int'(b));
          3'd5: tk = (int'(a) >= int'(b));
          3'd6: tk = (a <  b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) nxt = m_pc + ib;
      end
      7'h03: begin
        e_addr = a + ii;
        if (f3 == 3'd2) begin e_ce = 1'b1; wr = 1'b1; res = m_dmem[e_addr[7:2]]; end
      end
      7'h23: begin
        e_addr = a + is;
        if (f3 == 3'd2) begin
          e_ce = 1'b1; e_we = 1'b1; e_wd = b;
          m_dmem[e_addr[7:2]] = b;
        end
      end
      7'h13, 7'h33: begin
        o = (op == 7'h13) ? ii : b;
        if (op == 7'h33) ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else if (f3 == 3'd1) ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else ok = 1'b1;
        case (f3)
          3'd0: res = (op == 7'h33 && f7 == 7'h20) ? a - o : a + o;
          3'd1: res = a << o[4:0];
          3'd2: res = (int'(a) < int'(o)) ? 32'd1 : 32'd0;
          3'd3: res = (a < o) ? 32'd1 : 32'd0;
          3'd4: res = a ^ o;
          3'd5: res = (f7 == 7'h20) ? 32'(int'(a) >>> o[4:0]) : a >> o[4:0];
          3'd6: res = a | o;
          default: res = a & o;
        endcase
        wr = ok;
      end
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
    m_pc = nxt;
  endtask

  // Runs in lockstep until x31 shows the end marker or the budget expires.
  task automatic run_program(input int max_cycles);
    logic        done, e_ce, e_we;
    logic [31:0] e_addr, e_wd, pc_before;
    done = 1'b0;
    we_count = 0;
    for (int cyc = 0; cyc < max_cycles && !done; cyc++) begin
      @(negedge clk);
      pc_before = m_pc;
      model_step(imem[m_pc[9:2]], e_ce, e_we, e_addr, e_wd);
      check_val("pc", inst_addr_o, pc_before);
      check_val("inst_ce", {31'd0, inst_ce_o}, 32'd1);
      check_val("data_ce", {31'd0, data_ce_o}, {31'd0, e_ce});
      check_val("data_we", {31'd0, data_we_o}, {31'd0, e_we});
      if (e_ce) check_val("data_addr", data_addr_o, e_addr);
      if (e_we) check_val("data_o", data_o, e_wd);
      if (data_we_o) we_count++;
      @(posedge clk);
      #1;
      if (dut.r_regs[31] == 32'hFFFF_FEFE) done = 1'b1;
    end
    check_val("end_marker_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic check_final_state(input string phase);
    for (int i = 0; i < 32; i++) check_val($sformatf("%s_x%0d", phase, i), dut.r_regs[i], m_regs[i]);
    for (int i = 0; i < 64; i++) check_val($sformatf("%s_mem%0d", phase, i), dmem[i], m_dmem[i]);
  endtask

  task automatic check_reset_state(input string phase);
    logic [31:0] any;
    any = 32'd0;
    for (int i = 0; i < 32; i++) any = any | dut.r_regs[i];
    check_val({phase, "_pc"}, inst_addr_o, 32'd0);
    check_val({phase, "_inst_ce"}, {31'd0, inst_ce_o}, 32'd0);
    check_val({phase, "_data_ce"}, {31'd0, data_ce_o}, 32'd0);
    check_val({phase, "_data_we"}, {31'd0, data_we_o}, 32'd0);
    check_val({phase, "_regs_or"}, any, 32'd0);
  endtask

  function automatic logic [31:0] gen_rand(input int widx);
    int kind, rd, rs1, rs2, f3, k;
    logic [31:0] imm, w;
    kind = $urandom_range(0, 11);
    rd   = $urandom_range(0, 30);
    rs1  = $urandom_range(0, 31);
    rs2  = $urandom_range(0, 31);
    f3   = $urandom_range(0, 7);
    imm  = $urandom;
    k    = $urandom_range(1, 16);
    case (kind)
      0: w = enc_u(imm[19:0], rd, 7'h37);
      1: w = enc_u(imm[19:0], rd, 7'h17);
      2, 3: begin
        if (f3 == 1) imm[11:5] = 7'h00;
        if (f3 == 5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        w = enc_i(imm, rs1, f3, rd, 7'h13);
      end
      4, 5: w = enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                      rs2, rs1, f3, rd);
      6: begin
        if (f3 == 2 || f3 == 3) f3 = f3 + 4;
        w = enc_b(32'(k * 4), rs2, rs1, f3);
      end
      7: w = enc_j(32'(k * 4), rd);
      8, 11: w = enc_i(imm, rs1, ($urandom_range(0, 3) == 0) ? f3 : 2, rd, 7'h03);
      9: w = enc_s(imm, rs2, rs1, ($urandom_range(0, 3) == 0) ? f3 : 2);
      default: w = ($urandom_range(0, 1) == 1) ? 32'h0 : {imm[31:7], 7'h7F};
    endcase
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 64; i++) dmem_init[i] = 32'h0;
    imem[0]  = enc_i(32'hFFFF_FFFF, 0, 0, 1, 7'h13);    // ADDI x1,x0,-1
    imem[1]  = enc_i(32'd5, 0, 0, 2, 7'h13);            // ADDI x2,x0,5
    imem[2]  = enc_r(7'h20, 1, 2, 0, 3);                // SUB  x3,x2,x1
    imem[3]  = enc_r(7'h00, 1, 2, 3, 4);                // SLTU x4,x2,x1
    imem[4]  = enc_i(32'h404, 1, 5, 5, 7'h13);          // SRAI x5,x1,4
    imem[5]  = enc_u(20'h12345, 6, 7'h37);              // LUI  x6,0x12345
    imem[6]  = enc_i(32'h678, 6, 0, 6, 7'h13);          // ADDI x6,x6,0x678
    imem[7]  = enc_s(32'd8, 6, 0, 2);                   // SW   x6,8(x0)
    imem[8]  = enc_i(32'd8, 0, 2, 7, 7'h03);            // LW   x7,8(x0)
    imem[9]  = enc_b(32'd8, 0, 0, 0);                   // BEQ  x0,x0,+8
    imem[10] = enc_i(32'd1, 0, 0, 8, 7'h13);            // ADDI x8,x0,1 (skipped)
    imem[11] = enc_b(32'd8, 0, 0, 1);                   // BNE  x0,x0,+8 (falls through)
    imem[12] = enc_i(32'd2, 0, 0, 9, 7'h13);            // ADDI x9,x0,2
    imem[13] = enc_j(32'd12, 1);                        // JAL  x1,+12
    imem[14] = enc_i(32'd3, 0, 0, 10, 7'h13);           // ADDI x10,x0,3
    imem[15] = enc_j(32'd12, 0);                        // JAL  x0,+12
    imem[16] = enc_i(32'd0, 1, 0, 0, 7'h67);            // JALR x0,0(x1)
    imem[17] = enc_i(32'd4, 0, 0, 11, 7'h13);           // ADDI x11,x0,4 (skipped)
    imem[18] = enc_i(32'd7, 0, 0, 0, 7'h13);            // ADDI x0,x0,7
    imem[19] = 32'h0000_0000;
    imem[20] = 32'h0000_007F;
    imem[21] = enc_i(32'hFFFF_FEFE, 0, 0, 31, 7'h13);   // ADDI x31,x0,-258
    model_reset();

    #150;
    check_reset_state("in_reset");
    #150;
    rst = 1'b0;
    #1;
    check_val("ce_before_first_edge", {31'd0, inst_ce_o}, 32'd0);
    @(posedge clk);
    run_program(100);
    check_final_state("directed");
    check_val("x3_sub", dut.r_regs[3], 32'd6);
    check_val("x4_sltu", dut.r_regs[4], 32'd1);
    check_val("x5_srai", dut.r_regs[5], 32'hFFFF_FFFF);
    check_val("x7_lw", dut.r_regs[7], 32'h1234_5678);
    check_val("mem2_sw", dmem[2], 32'h1234_5678);
    check_val("sw_cycles", 32'(we_count), 32'd1);
    check_val("x8_beq_skip", dut.r_regs[8], 32'd0);
    check_val("x9_bne_fall", dut.r_regs[9], 32'd2);
    check_val("x1_jal_link", dut.r_regs[1], 32'd56);
    check_val("x10_jalr_ret", dut.r_regs[10], 32'd3);
    check_val("x11_jal_skip", dut.r_regs[11], 32'd0);
    check_val("x0_zero", dut.r_regs[0], 32'd0);
    check_val("x31_marker", dut.r_regs[31], 32'hFFFF_FEFE);

    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_state("async_reset");
      for (int i = 0; i < 256; i++) imem[i] = 32'h0;
      for (int i = 0; i < 200; i++) imem[i] = gen_rand(i);
      imem[255] = enc_i(32'hFFFF_FEFE, 0, 0, 31, 7'h13);
      for (int i = 0; i < 64; i++) dmem_init[i] = $urandom;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      run_program(1000);
      check_final_state($sformatf("random%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
